// File: rtl/enq_allocator_if.sv
// Enqueue-allocator bus: enqueue handshake, dequeue release, flush and the
// registered occupancy status that the allocator reports back.
interface enq_allocator_if #(
  parameter int NumEntries = 4,
  parameter int NumEnq     = 2
);
  localparam int CntW = $clog2(NumEntries + 1);

  // Enqueue side
  logic [NumEnq-1:0]                 enq_valid_i;
  logic [NumEnq-1:0]                 enq_ready_o;
  logic [NumEnq-1:0]                 enq_fire_o;
  logic [NumEnq-1:0][NumEntries-1:0] enq_mask_o;

  // Dequeue / flush side
  logic                              deq_fire_i;
  logic [NumEntries-1:0]             deq_mask_i;
  logic                              flush_i;

  // Status
  logic [NumEntries-1:0]             entry_vld_o;
  logic [CntW-1:0]                   count_o;
  logic                              full_o;
  logic                              empty_o;
  logic                              error_o;

  // Requester / queue controller side
  modport master (
    output enq_valid_i, deq_fire_i, deq_mask_i, flush_i,
    input  enq_ready_o, enq_fire_o, enq_mask_o,
    input  entry_vld_o, count_o, full_o, empty_o, error_o
  );

  // Allocator side
  modport slave (
    input  enq_valid_i, deq_fire_i, deq_mask_i, flush_i,
    output enq_ready_o, enq_fire_o, enq_mask_o,
    output entry_vld_o, count_o, full_o, empty_o, error_o
  );
endinterface

// File: rtl/enq_allocator.sv
// Enqueue allocator: tracks which of NumEntries queue entries are occupied,
// hands each enqueue port a distinct free entry (port j gets the (j+1)-th
// lowest free index), and releases entries on dequeue. Occupancy and a
// sticky illegal-dequeue flag are kept in registers.
module enq_allocator #(
  parameter int NumEntries = 4,
  parameter int NumEnq     = 2
) (
  input logic            clk_i,
  input logic            rst_ni,
  enq_allocator_if.slave bus
);
  localparam int CntW = $clog2(NumEntries + 1);

  // Number of set bits in an entry-wide vector.
  function automatic logic [CntW-1:0] popcount_entries(input logic [NumEntries-1:0] v);
    logic [CntW-1:0] c;
    c = '0;
    for (int i = 0; i < NumEntries; i++) begin
      c = c + CntW'(v[i]);
    end
    return c;
  endfunction

  // Number of set bits in a port-wide vector (NumEnq <= NumEntries, so it fits).
  function automatic logic [CntW-1:0] popcount_ports(input logic [NumEnq-1:0] v);
    logic [CntW-1:0] c;
    c = '0;
    for (int j = 0; j < NumEnq; j++) begin
      c = c + CntW'(v[j]);
    end
    return c;
  endfunction

  // Registered state
  logic [NumEntries-1:0]             vld_p1;
  logic [CntW-1:0]                   cnt_p1;
  logic                              err_p1;

  // Combinational allocation / release datapath
  logic [NumEntries-1:0]             free_p0;
  logic [NumEnq-1:0][NumEntries-1:0] cand_mask_p0;
  logic [NumEnq-1:0][NumEntries-1:0] enq_mask_p0;
  logic [NumEnq-1:0]                 rdy_p0;
  logic [NumEnq-1:0]                 fire_p0;
  logic [NumEntries-1:0]             deq_eff_p0;
  logic                              illegal_deq_p0;
  logic [NumEntries-1:0]             enq_set_p0;
  logic [NumEntries-1:0]             vld_nxt_p0;
  logic [CntW-1:0]                   cnt_nxt_p0;

  // Only entries free at the start of the cycle are allocatable, so an entry
  // being dequeued this cycle is never handed out again until next cycle.
  assign free_p0 = ~vld_p1;

  // Walk free entries from index 0 upward; the k-th one found goes to port k.
  always_comb begin : alloc_comb
    int seen;
    cand_mask_p0 = '0;
    seen         = 0;
    for (int i = 0; i < NumEntries; i++) begin
      if (free_p0[i]) begin
        for (int j = 0; j < NumEnq; j++) begin
          if (seen == j) begin
            cand_mask_p0[j][i] = 1'b1;
          end
        end
        seen = seen + 1;
      end
    end
  end

  // Ready depends only on free entries and flush, never on enq_valid_i.
  always_comb begin
    rdy_p0      = '0;
    enq_mask_p0 = '0;
    fire_p0     = '0;
    for (int j = 0; j < NumEnq; j++) begin
      rdy_p0[j]      = ~bus.flush_i & (|cand_mask_p0[j]);
      enq_mask_p0[j] = rdy_p0[j] ? cand_mask_p0[j] : '0;
      fire_p0[j]     = bus.enq_valid_i[j] & rdy_p0[j];
    end
  end

  // Dequeue releases only valid entries; mask bits on empty entries are errors.
  always_comb begin
    deq_eff_p0     = '0;
    illegal_deq_p0 = 1'b0;
    if (bus.deq_fire_i && !bus.flush_i) begin
      deq_eff_p0     = bus.deq_mask_i & vld_p1;
      illegal_deq_p0 = |(bus.deq_mask_i & ~vld_p1);
    end
  end

  // Next-state: set fired allocations, clear released entries, flush wins.
  always_comb begin
    enq_set_p0 = '0;
    for (int j = 0; j < NumEnq; j++) begin
      if (fire_p0[j]) begin
        enq_set_p0 = enq_set_p0 | enq_mask_p0[j];
      end
    end
    if (bus.flush_i) begin
      vld_nxt_p0 = '0;
      cnt_nxt_p0 = '0;
    end else begin
      vld_nxt_p0 = (vld_p1 & ~deq_eff_p0) | enq_set_p0;
      cnt_nxt_p0 = cnt_p1 + popcount_ports(fire_p0) - popcount_entries(deq_eff_p0);
    end
  end

  // ---- stage boundary: p0 combinational -> p1 registered state ----
  // Entry state, occupancy and sticky error; reset discards any in-flight update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1 <= '0;
      cnt_p1 <= '0;
      err_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_nxt_p0;
      cnt_p1 <= cnt_nxt_p0;
      err_p1 <= err_p1 | illegal_deq_p0;
    end
  end

  assign bus.enq_ready_o = rdy_p0;
  assign bus.enq_fire_o  = fire_p0;
  assign bus.enq_mask_o  = enq_mask_p0;
  assign bus.entry_vld_o = vld_p1;
  assign bus.count_o     = cnt_p1;
  assign bus.full_o      = (cnt_p1 == CntW'(NumEntries));
  assign bus.empty_o     = (cnt_p1 == '0);
  assign bus.error_o     = err_p1;
endmodule

// File: tb/tb_enq_allocator.sv
// Scoreboard bench for enq_allocator (NumEntries = 4, NumEnq = 2): the driver
// applies hand-computed vectors and queues their expected responses; a
// monitor on the falling edge pops and compares every output field.
module tb_enq_allocator;
  logic clk;
  logic rst_ni;

  enq_allocator_if #(.NumEntries(4), .NumEnq(2)) bus ();

  enq_allocator #(.NumEntries(4), .NumEnq(2)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] rdy;
    logic [1:0] fire;
    logic [3:0] m0;
    logic [3:0] m1;
    logic [3:0] vld;
    logic [2:0] cnt;
    logic       full;
    logic       empty;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compare everything the DUT presents in the cycle a vector is applied.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.name, ".ready"}, 32'(bus.enq_ready_o),   32'(e.rdy));
      chk({e.name, ".fire"},  32'(bus.enq_fire_o),    32'(e.fire));
      chk({e.name, ".mask0"}, 32'(bus.enq_mask_o[0]), 32'(e.m0));
      chk({e.name, ".mask1"}, 32'(bus.enq_mask_o[1]), 32'(e.m1));
      chk({e.name, ".vld"},   32'(bus.entry_vld_o),   32'(e.vld));
      chk({e.name, ".count"}, 32'(bus.count_o),       32'(e.cnt));
      chk({e.name, ".full"},  32'(bus.full_o),        32'(e.full));
      chk({e.name, ".empty"}, 32'(bus.empty_o),       32'(e.empty));
      chk({e.name, ".error"}, 32'(bus.error_o),       32'(e.err));
    end
  end

  // Apply one vector just after the rising edge and queue its expected response.
  // vld/cnt/err are the state visible this cycle; rdy/fire/masks follow the inputs.
  task automatic apply(input string nm, input logic [1:0] ev, input logic df,
                       input logic [3:0] dm, input logic fl,
                       input logic [1:0] rdy, input logic [1:0] fire,
                       input logic [3:0] m0, input logic [3:0] m1,
                       input logic [3:0] vld, input logic [2:0] cnt, input logic err);
    exp_t e;
    @(posedge clk);
    #1;
    bus.enq_valid_i = ev;
    bus.deq_fire_i  = df;
    bus.deq_mask_i  = dm;
    bus.flush_i     = fl;
    e.name  = nm;
    e.rdy   = rdy;
    e.fire  = fire;
    e.m0    = m0;
    e.m1    = m1;
    e.vld   = vld;
    e.cnt   = cnt;
    e.full  = (cnt == 3'd4);
    e.empty = (cnt == 3'd0);
    e.err   = err;
    sb.push_back(e);
  endtask

  initial begin
    int waitc;
    rst_ni          = 1'b0;
    bus.enq_valid_i = '0;
    bus.deq_fire_i  = 1'b0;
    bus.deq_mask_i  = '0;
    bus.flush_i     = 1'b0;

    //     name     ev     df    dm       fl    rdy    fire   m0       m1       vld      cnt   err
    apply("rst",   2'b00, 1'b0, 4'b0000, 1'b0, 2'b11, 2'b00, 4'b0001, 4'b0010, 4'b0000, 3'd0, 1'b0);
    #6 rst_ni = 1'b1;
    apply("enq01", 2'b11, 1'b0, 4'b0000, 1'b0, 2'b11, 2'b11, 4'b0001, 4'b0010, 4'b0000, 3'd0, 1'b0);
    apply("enq23", 2'b11, 1'b0, 4'b0000, 1'b0, 2'b11, 2'b11, 4'b0100, 4'b1000, 4'b0011, 3'd2, 1'b0);
    apply("fulldq",2'b11, 1'b1, 4'b0100, 1'b0, 2'b00, 2'b00, 4'b0000, 4'b0000, 4'b1111, 3'd4, 1'b0);
    apply("noreal",2'b01, 1'b1, 4'b0001, 1'b0, 2'b01, 2'b01, 4'b0100, 4'b0000, 4'b1011, 3'd3, 1'b0);
    apply("dqoff", 2'b00, 1'b0, 4'b0001, 1'b0, 2'b01, 2'b00, 4'b0001, 4'b0000, 4'b1110, 3'd3, 1'b0);
    apply("deq2",  2'b00, 1'b1, 4'b1100, 1'b0, 2'b01, 2'b00, 4'b0001, 4'b0000, 4'b1110, 3'd3, 1'b0);
    apply("gap",   2'b01, 1'b0, 4'b0000, 1'b0, 2'b11, 2'b01, 4'b0001, 4'b0100, 4'b0010, 3'd1, 1'b0);
    apply("illdq", 2'b00, 1'b1, 4'b0110, 1'b0, 2'b11, 2'b00, 4'b0100, 4'b1000, 4'b0011, 3'd2, 1'b0);
    apply("sticky",2'b11, 1'b0, 4'b0000, 1'b0, 2'b11, 2'b11, 4'b0010, 4'b0100, 4'b0001, 3'd1, 1'b1);
    apply("flush", 2'b11, 1'b1, 4'b0001, 1'b1, 2'b00, 2'b00, 4'b0000, 4'b0000, 4'b0111, 3'd3, 1'b1);
    apply("aftfl", 2'b11, 1'b0, 4'b0000, 1'b0, 2'b11, 2'b11, 4'b0001, 4'b0010, 4'b0000, 3'd0, 1'b1);
    apply("infl",  2'b11, 1'b0, 4'b0000, 1'b0, 2'b11, 2'b11, 4'b0100, 4'b1000, 4'b0011, 3'd2, 1'b1);
    // Asynchronous reset lands between edges, discarding the pending enqueue.
    #6 rst_ni = 1'b0;
    apply("inrst", 2'b00, 1'b0, 4'b0000, 1'b0, 2'b11, 2'b00, 4'b0001, 4'b0010, 4'b0000, 3'd0, 1'b0);
    #6 rst_ni = 1'b1;
    apply("postrs",2'b00, 1'b0, 4'b0000, 1'b0, 2'b11, 2'b00, 4'b0001, 4'b0010, 4'b0000, 3'd0, 1'b0);

    waitc = 0;
    while (sb.size() > 0 && waitc < 20) begin
      @(posedge clk);
      waitc++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0 pending", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/enq_allocator.md
ENQ_ALLOCATOR -- requirements
Module: enq_allocator

Interface
REQ-001 SHALL have parameter NumEntries, default 4, meaning the number of queue entries tracked.
REQ-002 SHALL have parameter NumEnq, default 2, meaning the number of enqueue ports; NumEnq <= NumEntries.
REQ-003 SHALL have clk_i  input  1  clock; reset rst_ni, asynchronous, active-low; clock clk_i.
REQ-004 SHALL have rst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have enq_valid_i  input  [NumEnq]  per-port enqueue request.
REQ-006 SHALL have enq_ready_o  output  [NumEnq]  per-port free entry available.
REQ-007 SHALL have enq_fire_o  output  [NumEnq]  enq_valid_i & enq_ready_o, for the age tracker.
REQ-008 SHALL have enq_mask_o  output  [NumEnq][NumEntries]  one-hot entry assigned to each port.
REQ-009 SHALL have deq_fire_i  input  1  dequeue strobe.
REQ-010 SHALL have deq_mask_i  input  [NumEntries]  entries released when deq_fire_i is high.
REQ-011 SHALL have flush_i  input  1  synchronous clear of all entries.
REQ-012 SHALL have entry_vld_o  output  [NumEntries]  registered valid vector.
REQ-013 SHALL have count_o  output  [$clog2(NumEntries+1)]  registered occupancy.
REQ-014 SHALL have full_o, empty_o  output  1 each  count_o == NumEntries / count_o == 0.
REQ-015 SHALL have error_o  output  1  sticky illegal-dequeue flag.

Function
REQ-016 Free vector SHALL be ~entry_vld_o; freeing by dequeue becomes visible the cycle after deq_fire_i.
REQ-017 Port j SHALL be assigned the (j+1)-th lowest-index free entry, independent of enq_valid_i of any port.
REQ-018 enq_ready_o[j] SHALL be 1 iff free-entry count > j and flush_i == 0; enq_ready_o SHALL NOT depend on enq_valid_i.
REQ-019 enq_mask_o[j] SHALL be one-hot when enq_ready_o[j] = 1 and all-zero otherwise.
REQ-020 Masks of different ports SHALL never overlap.
REQ-021 Next valid SHALL be (vld & ~(deq_fire_i ? deq_mask_i : 0)) | OR of enq_mask_o[j] over fired ports; latency 1 cycle.
REQ-022 count_o SHALL update by +popcount(enq_fire_o) - popcount(deq_fire_i ? deq_mask_i & vld : 0) each cycle and SHALL always equal popcount(entry_vld_o).
REQ-023 Simultaneous enqueue and dequeue SHALL both take effect; a dequeued entry SHALL NOT be reallocated in the same cycle.
REQ-024 deq_mask_i bits on invalid entries SHALL be ignored for state update and SHALL set error_o to 1 the next cycle, held until reset.
REQ-025 deq_fire_i = 0 SHALL ignore deq_mask_i entirely, including for error detection.
REQ-026 flush_i = 1 SHALL force all enq_ready_o, enq_fire_o, and enq_mask_o to 0, and SHALL clear entry_vld_o and count_o to 0 next cycle, overriding deq; error_o SHALL be unaffected.
REQ-027 Full (count_o == NumEntries) SHALL give enq_ready_o all zero; dequeue while full SHALL be accepted.

Reset
REQ-028 On rst_ni low, asynchronously: entry_vld_o = 0, count_o = 0, empty_o = 1, full_o = 0, error_o = 0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight enqueue/dequeue effects; the first cycle after release SHALL show all ports ready.

Verification (NumEntries = 4, NumEnq = 2)
REQ-030 Post-reset, enq_valid_i = 11 -> enq_ready_o = 11, masks 0001/0010; next cycle entry_vld_o = 0011, count_o = 2.
REQ-031 From vld = 0011, enq_valid_i = 11 -> masks 0100/1000; next cycle vld = 1111, full_o = 1, enq_ready_o = 00.
REQ-032 From vld = 1111, deq_fire_i = 1, mask 0100, enq_valid_i = 11 -> no fire; next vld = 1011, count_o = 3, enq_ready_o = 01 with port0 mask 0100.
REQ-033 From vld = 1011, deq mask 0001 plus port0 enqueue -> port0 gets 0100, not 0001; next vld = 1110, count_o = 3.
REQ-034 From vld = 0011, deq_fire_i = 1, mask 0110 -> next vld = 0001, count_o = 1, error_o = 1 and remains 1 through later traffic until reset.
REQ-035 From vld = 0111, flush_i = 1 with enq_valid_i = 11 -> enq_fire_o = 00; next vld = 0000, empty_o = 1; error_o unchanged.
